// File: rtl/noise_voice_pkg.sv
// Shared audio definitions for the noise voice: FSM state type, hold reset value
// and the offset-binary to two's-complement conversion.
package noise_voice_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCALE,
    PRESENT
  } nv_state_t;

  localparam logic [7:0] NOISE_HOLD_RESET = 8'h80;

  // Offset-binary 0x80 is mid-scale, so flipping the MSB yields the signed value.
  function automatic logic signed [7:0] offset_to_signed(input logic [7:0] b);
    return $signed(b ^ 8'h80);
  endfunction

endpackage

// File: rtl/noise_voice_if.sv
// Sample handshake between the noise voice (master) and the downstream mixer (slave).
interface noise_voice_if;
  logic signed [7:0] out_sample;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_sample, output out_valid, input out_ready);
  modport slave  (input out_sample, input out_valid, output out_ready);
endinterface

// File: rtl/noise_voice_scale.sv
// nv_scale: registered signed sample x unsigned volume; the result keeps the
// upper byte of the product (arithmetic shift, truncation toward minus infinity).
module nv_scale #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] sample,
  input  logic [COEF_W-1:0]        volume,
  input  logic                     gate,
  output logic signed [DATA_W-1:0] scaled
);

  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam logic signed [PROD_W-1:0] MAXV = PROD_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] MINV = -MAXV - PROD_W'(1);

  logic signed [PROD_W-1:0] prod_p0;

  // The clamp never engages for 8x8 operands; it only pins down the narrowing.
  function automatic logic signed [DATA_W-1:0] narrow(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W-1:0] sh;
    sh = p >>> COEF_W;
    if (sh > MAXV)      return MAXV[DATA_W-1:0];
    else if (sh < MINV) return MINV[DATA_W-1:0];
    else                return sh[DATA_W-1:0];
  endfunction

  // stage p0: product register, loaded on the SCALE edge
  always_ff @(posedge clk) begin
    if (en)
      prod_p0 <= gate ? PROD_W'(sample) * PROD_W'($signed({1'b0, volume})) : '0;
  end

  assign scaled = narrow(prod_p0);

endmodule

// File: rtl/noise_voice.sv
// Noise oscillator voice: phase accumulator gates resampling of the LFSR byte,
// which is volume-scaled and handed to the mixer. Optional hard sync: NOISE_VOICE_SYNC_EN.
module noise_voice
  import noise_voice_pkg::*;
#(
  parameter int ACC_W  = 24,
  parameter int FREQ_W = 16,
  parameter int TAP    = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic [FREQ_W-1:0] freq,
  input  logic [7:0]        volume,
  input  logic              gate,
  input  logic [7:0]        noise_in,
`ifdef NOISE_VOICE_SYNC_EN
  input  logic              sync,
`endif
  noise_voice_if.master     bus,
  output logic              overrun
);

  nv_state_t         state;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  freq_ext;
  logic              tap_prev;
  logic [7:0]        hold;
  logic signed [7:0] out_sample_r;
  logic              out_valid_r;
  logic signed [7:0] scaled;
  logic              sync_hit;

`ifdef NOISE_VOICE_SYNC_EN
  assign sync_hit = sync;
`else
  assign sync_hit = 1'b0;
`endif

  assign freq_ext = ACC_W'(freq);

  nv_scale #(.DATA_W(8), .COEF_W(8)) u_scale (
    .clk    (clk),
    .en     (state == SCALE),
    .sample (offset_to_signed(hold)),
    .volume (volume),
    .gate   (gate),
    .scaled (scaled)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      tap_prev     <= 1'b0;
      hold         <= NOISE_HOLD_RESET;
      out_sample_r <= '0;
      out_valid_r  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      // A tick outside IDLE is lost; remember that it happened.
      if (sample_tick && state != IDLE)
        overrun <= 1'b1;

      // Sync takes priority over a coincident increment.
      if (sync_hit) begin
        acc      <= '0;
        tap_prev <= 1'b0;
      end else if (sample_tick && state == IDLE) begin
        acc      <= acc + freq_ext;
        tap_prev <= acc[TAP];
      end

      case (state)
        IDLE: begin
          if (sample_tick) state <= ACCUM;
        end
        // stage: resample on a 0->1 edge of the tap bit only
        ACCUM: begin
          if (acc[TAP] && !tap_prev) hold <= noise_in;
          state <= SCALE;
        end
        // stage: nv_scale captures the product on this edge
        SCALE: begin
          state <= PRESENT;
        end
        // stage: publish once, then hold steady until the mixer takes it
        PRESENT: begin
          if (!out_valid_r) begin
            out_valid_r  <= 1'b1;
            out_sample_r <= scaled;
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_sample = out_sample_r;
  assign bus.out_valid  = out_valid_r;

endmodule
